// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, idle fill pattern and FSM state encoding for the SPI slave
package spi_pkg;
    localparam int N_DEF = 8;
    localparam logic FILL_BIT = 1'b1;
    localparam logic [N_DEF-1:0] FILL_DEF = {N_DEF{FILL_BIT}};
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel tx/rx handshake of the SPI slave
interface spi_slave_if #(parameter int N = spi_pkg::N_DEF);
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, busy
    );
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous input with rise/fall pulses on the synchronized level
module sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta, r_sync, r_prev;

    // two synchronizing stages plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 MSB-first slave with a one-word transmit holding buffer
module spi_slave
    import spi_pkg::*;
#(
    parameter int          N    = N_DEF,
    parameter logic [N-1:0] FILL = {N{FILL_BIT}}
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(N);

    state_t         r_state, w_state_nxt;
    logic           w_sclk_unused, w_sclk_rise, w_sclk_fall;
    logic           w_cs_sync, w_cs_rise, w_cs_fall;
    logic           r_mosi_meta, r_mosi;
    logic [1:0]     r_settle;
    logic           r_armed;
    logic           w_start, w_enter, w_leave, w_rx_step, w_tx_step;
    logic           w_word_end, w_load, w_cap;
    logic [N-1:0]   w_word;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_rx_sr, r_tx_sr, r_rx_data, r_buf;
    logic           r_rx_valid, r_miso, r_buf_full;

    sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.sclk),
        .o_sync  (w_sclk_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // mosi only needs resynchronizing; it is sampled on the sclk rise pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mosi_meta <= 1'b1;
            r_mosi      <= 1'b1;
        end else begin
            r_mosi_meta <= bus.mosi;
            r_mosi      <= r_mosi_meta;
        end
    end

    // a transfer may only start after cs_n has truly been seen high since reset,
    // so a chip select still held low across reset cannot look like a fresh fall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[0], 1'b1};
            if (r_settle[1] && w_cs_sync) r_armed <= 1'b1;
        end
    end

    assign w_start = w_cs_fall & r_armed;

    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_state_nxt;
    end

    // next state and per-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        w_rx_step   = 1'b0;
        w_tx_step   = 1'b0;
        if (r_state == IDLE) begin
            w_enter     = w_start;
            w_state_nxt = w_start ? SHIFT : IDLE;
        end else begin
            w_leave     = w_cs_rise;
            w_rx_step   = !w_cs_rise && w_sclk_rise;
            w_tx_step   = !w_cs_rise && w_sclk_fall;
            w_state_nxt = w_cs_rise ? IDLE : SHIFT;
        end
    end

    assign w_word_end = w_rx_step && (r_cnt == CW'(N - 1));
    assign w_load     = w_enter || (w_tx_step && r_cnt == '0);
    assign w_word     = r_buf_full ? r_buf : FILL;
    assign w_cap      = bus.tx_valid && !r_buf_full;

    // receive shifter, bit counter and completed-word register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_word_end;
            if (w_enter || w_leave) begin
                r_cnt   <= '0;
                r_rx_sr <= '0;
            end else if (w_rx_step) begin
                r_rx_sr <= {r_rx_sr[N-2:0], r_mosi};
                r_cnt   <= w_word_end ? '0 : CW'(r_cnt + 1'b1);
            end
            if (w_word_end) r_rx_data <= {r_rx_sr[N-2:0], r_mosi};
        end
    end

    // transmit shifter; miso is registered and only moves on a load or an sclk fall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_sr <= '0;
            r_miso  <= 1'b1;
        end else if (w_leave) begin
            r_tx_sr <= '0;
            r_miso  <= 1'b1;
        end else if (w_load) begin
            r_tx_sr <= w_word;
            r_miso  <= w_word[N-1];
        end else if (w_tx_step) begin
            r_tx_sr <= {r_tx_sr[N-2:0], 1'b0};
            r_miso  <= r_tx_sr[N-2];
        end
    end

    // holding buffer: a load consumes the pre-cycle contents, a capture refills for the next word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_cap) begin
            r_buf      <= bus.tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    assign bus.miso     = r_miso;
    assign bus.tx_ready = ~r_buf_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = (r_state == SHIFT);
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized master/feeder stimulus checked against a word-level SPI slave model
module tb_spi_slave;
    localparam logic [7:0] FILLV = 8'hFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_if #(.N(8)) bus();

    spi_slave #(.N(8), .FILL(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       feed     = 1'b0;
    logic       rdy_prev = 1'b0;
    logic [7:0] mo_w[4];
    logic [7:0] mi_w[4];
    logic [7:0] last_rx = 8'h00;

    // one clk cycle: collect rx words and, when enabled, stream txq into the holding buffer
    task automatic tick();
        @(negedge clk);
        if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
        if (feed) begin
            if (bus.tx_valid && rdy_prev) txq.delete(0);
            bus.tx_valid = (txq.size() > 0);
            if (txq.size() > 0) bus.tx_data = txq[0];
        end
        rdy_prev = bus.tx_ready;
    endtask

    task automatic load_tx(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    // mode-0 master: set mosi while sclk low, sample miso just before the rising edge
    task automatic xfer_bits(input int h, input logic [7:0] mo, input int nb, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 7; b > 7 - nb; b--) begin
            bus.mosi = mo[b];
            repeat (h) tick();
            mi = {mi[6:0], bus.miso};
            bus.sclk = 1'b1;
            repeat (h) tick();
            bus.sclk = 1'b0;
        end
    endtask

    task automatic transfer(input int h, input int nw);
        bus.cs_n = 1'b0;
        for (int w = 0; w < nw; w++) xfer_bits(h, mo_w[w], 8, mi_w[w]);
        repeat (h) tick();
        bus.cs_n = 1'b1;
        repeat (8) tick();
    endtask

    // compare one transfer against the model: word w carries exp_tx[w] out and mo_w[w] in
    task automatic check_words(input string nm, input int nw, input logic [7:0] exp_tx[4]);
        n_chk++;
        if (rxq.size() != nw) begin
            n_fail++;
            $display("FAIL %s_rx_count: got %0d expected %0d", nm, rxq.size(), nw);
        end
        for (int w = 0; w < nw; w++) begin
            n_chk++;
            if (mi_w[w] !== exp_tx[w]) begin
                n_fail++;
                $display("FAIL %s_miso_w%0d: got %h expected %h", nm, w, mi_w[w], exp_tx[w]);
            end
            n_chk++;
            if (w >= rxq.size() || rxq[w] !== mo_w[w]) begin
                n_fail++;
                $display("FAIL %s_rx_w%0d: got %h expected %h", nm, w, (w < rxq.size()) ? rxq[w] : 8'hxx, mo_w[w]);
            end
        end
        if (nw > 0) last_rx = mo_w[nw-1];
    endtask

    task automatic test_reset();
        bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_chk++; if (bus.miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b expected 1", bus.miso); end
        n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
        n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        repeat (4) tick();
        rxq.delete();
    endtask

    task automatic test_basic();
        logic [7:0] ex[4];
        rxq.delete();
        load_tx(8'hA5);
        n_chk++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_tx_ready_full: got %b expected 0", bus.tx_ready); end
        mo_w[0] = 8'h3C;
        transfer(8, 1);
        ex = '{8'hA5, FILLV, FILLV, FILLV};
        check_words("basic", 1, ex);
        n_chk++; if (bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data: got %h expected 3c", bus.rx_data); end
        n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_tx_ready_empty: got %b expected 1", bus.tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex[4];
        rxq.delete();
        load_tx(8'h81);
        mo_w[0] = 8'($urandom); mo_w[1] = 8'($urandom);
        transfer(8, 2);
        ex = '{8'h81, FILLV, FILLV, FILLV};
        check_words("b2b", 2, ex);
        rxq.delete();
        ex[0] = 8'($urandom); ex[1] = 8'($urandom); ex[2] = FILLV;
        txq.delete(); txq.push_back(ex[0]); txq.push_back(ex[1]);
        for (int w = 0; w < 3; w++) mo_w[w] = 8'($urandom);
        feed = 1'b1;
        repeat (6) tick();
        transfer(6, 3);
        feed = 1'b0; bus.tx_valid = 1'b0;
        check_words("b2b_fed", 3, ex);
    endtask

    task automatic test_abort();
        logic [7:0] x, mi, ex[4];
        rxq.delete();
        x = 8'($urandom);
        bus.cs_n = 1'b0;
        repeat (4) tick();
        load_tx(x);
        xfer_bits(8, 8'($urandom), 5, mi);
        repeat (8) tick();
        bus.cs_n = 1'b1;
        repeat (8) tick();
        n_chk++; if (rxq.size() != 0) begin n_fail++; $display("FAIL abort_no_rx_valid: got %0d pulses expected 0", rxq.size()); end
        n_chk++; if (bus.rx_data !== last_rx) begin n_fail++; $display("FAIL abort_rx_data: got %h expected %h", bus.rx_data, last_rx); end
        n_chk++; if (bus.miso !== 1'b1) begin n_fail++; $display("FAIL abort_miso: got %b expected 1", bus.miso); end
        n_chk++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL abort_buffer_kept: got %b expected 0", bus.tx_ready); end
        mo_w[0] = 8'($urandom);
        transfer(8, 1);
        ex = '{x, FILLV, FILLV, FILLV};
        check_words("after_abort", 1, ex);
    endtask

    // tx_valid lands exactly on the cs_n-fall load cycle (third clk edge after cs_n drops)
    task automatic test_boundary_capture();
        logic [7:0] d, ex[4];
        rxq.delete();
        d = 8'($urandom_range(254, 0));
        mo_w[0] = 8'($urandom); mo_w[1] = 8'($urandom);
        bus.cs_n = 1'b0;
        tick();
        tick();
        bus.tx_data = d; bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        n_chk++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL cap_tx_ready_low: got %b expected 0", bus.tx_ready); end
        xfer_bits(8, mo_w[0], 8, mi_w[0]);
        repeat (4) tick();
        n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL cap_tx_ready_back: got %b expected 1", bus.tx_ready); end
        xfer_bits(8, mo_w[1], 8, mi_w[1]);
        repeat (8) tick();
        bus.cs_n = 1'b1;
        repeat (8) tick();
        ex = '{FILLV, d, FILLV, FILLV};
        check_words("cap", 2, ex);
    endtask

    task automatic test_reset_mid();
        logic [7:0] mo, mi, ex[4];
        rxq.delete();
        mo = 8'($urandom);
        bus.cs_n = 1'b0;
        repeat (4) tick();
        load_tx(8'($urandom));
        xfer_bits(8, mo, 4, mi);
        reset = 1'b1;
        tick();
        n_chk++; if (bus.miso !== 1'b1) begin n_fail++; $display("FAIL rstmid_miso: got %b expected 1", bus.miso); end
        n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b expected 1", bus.tx_ready); end
        n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b expected 0", bus.rx_valid); end
        n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 00", bus.rx_data); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        last_rx = 8'h00;
        xfer_bits(8, mo << 4, 4, mi);
        repeat (8) tick();
        bus.cs_n = 1'b1;
        repeat (8) tick();
        n_chk++; if (rxq.size() != 0) begin n_fail++; $display("FAIL rstmid_no_rx_valid: got %0d pulses expected 0", rxq.size()); end
        n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data_kept: got %h expected 00", bus.rx_data); end
        mo_w[0] = 8'($urandom);
        transfer(8, 1);
        ex = '{FILLV, FILLV, FILLV, FILLV};
        check_words("after_rstmid", 1, ex);
    endtask

    task automatic test_fast();
        logic [7:0] ex[4];
        rxq.delete();
        ex = '{8'h55, 8'hAA, 8'h55, 8'hAA};
        mo_w = '{8'hAA, 8'h55, 8'hAA, 8'h55};
        txq.delete();
        for (int w = 0; w < 4; w++) txq.push_back(ex[w]);
        feed = 1'b1;
        repeat (6) tick();
        transfer(4, 4);
        feed = 1'b0; bus.tx_valid = 1'b0;
        check_words("fast", 4, ex);
    endtask

    task automatic test_random();
        logic [7:0] ex[4];
        int h, nw, ntx;
        for (int t = 0; t < 6; t++) begin
            rxq.delete();
            h   = $urandom_range(8, 4);
            nw  = $urandom_range(3, 1);
            ntx = $urandom_range(nw, 0);
            txq.delete();
            for (int w = 0; w < 4; w++) begin
                ex[w]   = (w < ntx) ? 8'($urandom) : FILLV;
                mo_w[w] = 8'($urandom);
                if (w < ntx) txq.push_back(ex[w]);
            end
            feed = 1'b1;
            repeat (6) tick();
            transfer(h, nw);
            feed = 1'b0; bus.tx_valid = 1'b0;
            check_words("random", nw, ex);
            n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL random_tx_ready_idle: got %b expected 1", bus.tx_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_boundary_capture();
        test_reset_mid();
        test_fast();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter N, default 8, shall set the SPI word width in bits.
REQ-002 Parameter FILL, default all-ones (8'hFF for N=8), shall set the word sent when no transmit data is buffered.
REQ-003 clk  input  1  system clock; all logic shall be clocked on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-006 cs_n  input  1  active-low chip select from the master, asynchronous to clk.
REQ-007 mosi  input  1  serial data from the master, asynchronous to clk.
REQ-008 miso  output  1  serial data to the master.
REQ-009 tx_data  input  N  next word to transmit.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  transmit holding buffer is empty.
REQ-012 rx_data  output  N  last complete received word.
REQ-013 rx_valid  output  1  one-clk pulse; rx_data has been updated.
REQ-014 busy  output  1  chip select is active (synchronized cs_n low).

Function
REQ-015 sclk, cs_n and mosi shall each pass through a 2-flop synchronizer before use; sclk and cs_n edges shall be detected on the synchronized signals.
REQ-016 SPI mode 0, MSB first: mosi shall be sampled on each detected sclk rising edge; miso shall change only on a detected sclk falling edge or a detected cs_n falling edge.
REQ-017 Correct operation shall be guaranteed for f_clk >= 8 x f_sclk; no behaviour is defined below that ratio.
REQ-018 FSM states: IDLE (cs_n high) and SHIFT (cs_n low); a detected cs_n fall shall move IDLE->SHIFT; a detected cs_n rise shall move SHIFT->IDLE.
REQ-019 On the IDLE->SHIFT transition, the tx shift register shall load the holding buffer (or FILL if the buffer is empty), and miso shall present its MSB in that same cycle. The bit counter shall be cleared in that same cycle.
REQ-020 In SHIFT, each detected sclk rise shall shift the synchronized mosi into the rx shift register LSB and increment the bit counter.
REQ-021 On the Nth sclk rise of a word, rx_data shall take the completed word and rx_valid shall pulse high for exactly one clk, one cycle after the edge-detect cycle. The counter shall wrap to 0.
REQ-022 On each detected sclk fall, miso shall output the next tx bit; when the counter is 0 (a word boundary), the tx register shall instead reload from the buffer/FILL and drive the new MSB.
REQ-023 tx_ready shall be high whenever the holding buffer is empty; a clk cycle with tx_valid && tx_ready shall capture tx_data and clear tx_ready on the next cycle.
REQ-024 A word load shall empty the buffer and use the buffer's pre-cycle contents; a capture in the same cycle shall fill the buffer for the following word, with no bypass.
REQ-025 rx has no backpressure: a new word shall overwrite rx_data regardless of consumption.
REQ-026 A cs_n rise mid-word shall abort the word. In that case:
- the partial rx bits shall be discarded and no rx_valid pulse shall be generated;
- the counter shall clear;
- a loaded tx word shall be discarded, and the holding buffer shall be unaffected.
REQ-027 In IDLE, miso shall be driven 1.

Reset
REQ-028 On reset, the outputs shall take these values: miso=1, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
REQ-029 On reset, the internal state shall take these values: state=IDLE, counter=0, both shift registers=0, holding buffer empty, synchronizers loaded with idle levels (sclk=0, cs_n=1, mosi=1).
REQ-030 Reset asserted mid-word shall abort the transfer with no rx_valid pulse, and the next word shall start only on a fresh cs_n fall.

Structure
REQ-031 A shared package spi_pkg shall hold the default N, the FILL constant and the FSM state encoding.
REQ-032 A single sub-module sync_edge (2-flop synchronizer plus rise/fall pulse outputs) shall be instantiated for sclk and cs_n; mosi shall use the synchronizer only.

Verification
REQ-033 Load tx_data=8'hA5, then master sends 8'h3C with f_clk=16 x f_sclk -> the master receives 8'hA5, and rx_valid pulses once with rx_data=8'h3C.
REQ-034 Two back-to-back words under one cs_n, with tx buffer loaded only before the first (8'h81) -> the master receives 8'h81 then 8'hFF, and two rx_valid pulses occur.
REQ-035 cs_n raised after 5 sclk rises -> no rx_valid, rx_data unchanged, miso=1; the next full word is received correctly from bit 0.
REQ-036 tx_valid asserted in the same clk as the word-boundary load with buffer empty -> the current word is FILL, the following word is the new data, and tx_ready drops for one word.
REQ-037 reset pulsed at bit 4 of a transfer -> all outputs return to the REQ-028 values next cycle, and no rx_valid occurs for that word.
REQ-038 f_clk = 8 x f_sclk with alternating 8'h55/8'hAA in both directions over 4 words -> all words intact.
